wave_scheduler: RTL and testbench
=================================

// Module: wave_scheduler
// PURPOSE
//  Sequences the wave_logic profile generator and shares it between two frequency requesters
//  (A = player input, B = game/music logic). Captures and clamps requests, arbitrates round-robin,
//  issues one new_f pulse per recalculation, waits for wave_ready (with timeout) and publishes
//  current/previous frequency plus a swap pulse to the display side.
// PARAMETERS
//  FREQ_W    11    width of all frequency buses
//  BASE_FREQ 220   lowest legal frequency; smaller requests clamp up to it
//  MAX_FREQ  1760  highest legal frequency; larger requests clamp down to it
//  TIMEOUT   2048  max cycles in WAIT before giving up (>= generator WIDTH + margin)
// PORTS
//  clock       in  1       single clock domain, all state on posedge
//  reset_n     in  1       asynchronous, active-low reset
//  req_a       in  1       requester A frequency valid (level, sampled each cycle)
//  freq_a      in  FREQ_W  requester A frequency
//  req_b       in  1       requester B frequency valid
//  freq_b      in  FREQ_W  requester B frequency
//  ack_a       out 1       1-cycle pulse: A request captured
//  ack_b       out 1       1-cycle pulse: B request captured
//  new_f       out 1       1-cycle pulse to generator: start calculation
//  frequency   out FREQ_W  frequency to generator, stable from new_f until next new_f
//  wave_ready  in  1       generator done pulse
//  busy        out 1       high when state != IDLE
//  cur_freq    out FREQ_W  frequency of the latest completed profile
//  prev_freq   out FREQ_W  frequency of the profile before cur_freq
//  swap        out 1       1-cycle pulse: cur/prev updated, new profile valid
//  timeout_err out 1       1-cycle pulse: WAIT expired without wave_ready
// BEHAVIOUR
//  Reset (reset_n=0, async): all outputs 0, cur/prev_freq 0, both slots empty, cur_valid=0,
//   last_grant=B (so A wins the first tie), state IDLE, wait counter 0.
//  Capture: per requester one slot {pending, value}. req_x=1 at edge -> pending_x<=1,
//   value_x<=clamp(freq_x), ack_x=1 next cycle. Always accepted in every state; a newer request
//   overwrites an unserved one (latest wins, ack still pulses).
//  clamp(f) = f<BASE_FREQ ? BASE_FREQ : f>MAX_FREQ ? MAX_FREQ : f; all compares unsigned FREQ_W.
//  FSM states: IDLE, WAIT (ISSUE folded into the IDLE exit edge; outputs registered).
//  IDLE: if no slot pending, stay. Else select: only one pending -> it; both -> the one != last_grant.
//   Selected value == cur_freq and cur_valid=1 -> drop (clear pending, no new_f, stay IDLE).
//   Otherwise at that edge: new_f<=1, frequency<=value, last_grant<=sel, clear sel pending,
//   counter<=0, state<=WAIT. new_f is high exactly one cycle.
//  Latency: req sampled at edge N -> pending at N -> new_f high after edge N+1 (if idle, no tie loss).
//  Same-edge capture and clear on the selected slot: new capture wins, slot stays pending.
//  WAIT: counter increments each cycle. wave_ready=1 -> prev_freq<=cur_freq, cur_freq<=frequency,
//   cur_valid<=1, swap=1 for one cycle, state<=IDLE. Counter reaches TIMEOUT-1 without ready ->
//   timeout_err=1 one cycle, cur/prev unchanged, state<=IDLE. ready on the timeout cycle counts as done.
//  wave_ready while IDLE is ignored. No preemption: requests during WAIT queue in slots.
//  Reset asserted mid-WAIT: immediate return to reset values; a late wave_ready is then ignored.
//  Back-to-back: earliest next new_f is the cycle after swap (IDLE re-evaluates on that edge).
// TESTING
//  1 Single: req_a=1 one cycle, freq_a=440 -> ack_a next cycle, new_f one cycle, frequency=440;
//    ready 1023 cycles later -> swap, cur_freq=440, prev_freq=0, busy low after.
//  2 Clamp: freq_b=100 -> frequency=220; freq_b=2000 -> frequency=1760.
//  3 Tie/round-robin: after reset req_a=330 and req_b=550 same cycle -> A issued first, B issued
//    cycle after A's swap; then both again -> A's turn? no: last_grant=B so A, alternating verified.
//  4 Overwrite during WAIT: A at 440 running, A requests 500 then 600 -> two acks, only 600 issued next.
//  5 Duplicate drop: cur_freq=440, req_a=440 -> ack_a, no new_f, busy stays 0.
//  6 Timeout/reset: hold wave_ready=0 -> timeout_err pulse at TIMEOUT, cur_freq unchanged;
//    repeat, drop reset_n mid-WAIT -> all outputs 0 asynchronously, later wave_ready ignored.

Source files
------------

// File: rtl/wave_scheduler.sv
// Shares one wave_logic profile generator between two frequency requesters: captures and clamps
// requests, arbitrates round-robin, issues new_f, waits for wave_ready and publishes cur/prev.
module wave_scheduler #(
  parameter int FREQ_W    = 11,
  parameter int BASE_FREQ = 220,
  parameter int MAX_FREQ  = 1760,
  parameter int TIMEOUT   = 2048
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_a,
  input  logic [FREQ_W-1:0] freq_a,
  input  logic              req_b,
  input  logic [FREQ_W-1:0] freq_b,
  output logic              ack_a,
  output logic              ack_b,
  output logic              new_f,
  output logic [FREQ_W-1:0] frequency,
  input  logic              wave_ready,
  output logic              busy,
  output logic [FREQ_W-1:0] cur_freq,
  output logic [FREQ_W-1:0] prev_freq,
  output logic              swap,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_e;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;

  function automatic logic [FREQ_W-1:0] clamp(input logic [FREQ_W-1:0] f);
    if (f < FREQ_W'(BASE_FREQ))     return FREQ_W'(BASE_FREQ);
    else if (f > FREQ_W'(MAX_FREQ)) return FREQ_W'(MAX_FREQ);
    else                            return f;
  endfunction

  state_e            state_q, state_d;
  logic              pend_a_q, pend_a_d, pend_b_q, pend_b_d;
  logic [FREQ_W-1:0] val_a_q, val_a_d, val_b_q, val_b_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_a_q, ack_a_d, ack_b_q, ack_b_d;
  logic              new_f_q, new_f_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [FREQ_W-1:0] cur_q, cur_d, prev_q, prev_d;
  logic              cur_valid_q, cur_valid_d;
  logic              swap_q, swap_d, tmo_q, tmo_d;
  logic              sel_b;
  logic [FREQ_W-1:0] sel_val;

  always_comb begin
    // NOTE: every signal gets a default here first, so no path can leave one unassigned (no latch).
    state_d      = state_q;
    pend_a_d     = pend_a_q;
    pend_b_d     = pend_b_q;
    val_a_d      = val_a_q;
    val_b_d      = val_b_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    freq_d       = freq_q;
    cur_d        = cur_q;
    prev_d       = prev_q;
    cur_valid_d  = cur_valid_q;
    ack_a_d      = req_a;
    ack_b_d      = req_b;
    new_f_d      = 1'b0;
    swap_d       = 1'b0;
    tmo_d        = 1'b0;
    sel_b        = 1'b0;
    sel_val      = val_a_q;

    case (state_q)
      ST_IDLE: begin
        if (pend_a_q || pend_b_q) begin
          // On a tie the requester that was not granted last goes first.
          sel_b   = (pend_a_q && pend_b_q) ? (last_grant_q == GRANT_A) : pend_b_q;
          sel_val = sel_b ? val_b_q : val_a_q;
          if (sel_b) pend_b_d = 1'b0;
          else       pend_a_d = 1'b0;
          if (!(cur_valid_q && (sel_val == cur_q))) begin
            new_f_d      = 1'b1;
            freq_d       = sel_val;
            last_grant_d = sel_b ? GRANT_B : GRANT_A;
            cnt_d        = '0;
            state_d      = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (wave_ready) begin
          prev_d      = cur_q;
          cur_d       = freq_q;
          cur_valid_d = 1'b1;
          swap_d      = 1'b1;
          state_d     = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Capture comes last so a request landing on the same edge as a grant keeps its slot pending.
    if (req_a) begin
      pend_a_d = 1'b1;
      val_a_d  = clamp(freq_a);
    end
    if (req_b) begin
      pend_b_d = 1'b1;
      val_b_d  = clamp(freq_b);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      pend_a_q     <= 1'b0;
      pend_b_q     <= 1'b0;
      val_a_q      <= '0;
      val_b_q      <= '0;
      last_grant_q <= GRANT_B;
      cnt_q        <= '0;
      ack_a_q      <= 1'b0;
      ack_b_q      <= 1'b0;
      new_f_q      <= 1'b0;
      freq_q       <= '0;
      cur_q        <= '0;
      prev_q       <= '0;
      cur_valid_q  <= 1'b0;
      swap_q       <= 1'b0;
      tmo_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_a_q     <= pend_a_d;
      pend_b_q     <= pend_b_d;
      val_a_q      <= val_a_d;
      val_b_q      <= val_b_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      ack_a_q      <= ack_a_d;
      ack_b_q      <= ack_b_d;
      new_f_q      <= new_f_d;
      freq_q       <= freq_d;
      cur_q        <= cur_d;
      prev_q       <= prev_d;
      cur_valid_q  <= cur_valid_d;
      swap_q       <= swap_d;
      tmo_q        <= tmo_d;
    end
  end

  assign ack_a       = ack_a_q;
  assign ack_b       = ack_b_q;
  assign new_f       = new_f_q;
  assign frequency   = freq_q;
  assign busy        = (state_q != ST_IDLE);
  assign cur_freq    = cur_q;
  assign prev_freq   = prev_q;
  assign swap        = swap_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_wave_scheduler.sv
// Bench for wave_scheduler: directed scenarios plus random traffic, every cycle compared
// against a request/slot reference model built from the scheduling rules.
module tb_wave_scheduler;

  localparam int FW   = 11;
  localparam int BASE = 220;
  localparam int MAXF = 1760;
  localparam int TMO  = 2048;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          req_a = 1'b0, req_b = 1'b0, wave_ready = 1'b0;
  logic [FW-1:0] freq_a = '0, freq_b = '0;
  logic          ack_a, ack_b, new_f, busy, swap, timeout_err;
  logic [FW-1:0] frequency, cur_freq, prev_freq;

  int checks = 0;
  int failures = 0;

  wave_scheduler #(.FREQ_W(FW), .BASE_FREQ(BASE), .MAX_FREQ(MAXF), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_a(req_a), .freq_a(freq_a), .req_b(req_b), .freq_b(freq_b),
    .ack_a(ack_a), .ack_b(ack_b), .new_f(new_f), .frequency(frequency),
    .wave_ready(wave_ready), .busy(busy), .cur_freq(cur_freq), .prev_freq(prev_freq),
    .swap(swap), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Reference model: two request slots, a "generator running" flag and elapsed-cycle count.
  int slot_pending[2];
  int slot_value[2];
  int last_winner;
  int running, elapsed;
  int m_freq, m_cur, m_prev, m_has_cur;
  int m_ack[2];
  int m_new_f, m_swap, m_tmo;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int clamp(input int f);
    return (f < BASE) ? BASE : (f > MAXF) ? MAXF : f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      slot_pending[i] = 0; slot_value[i] = 0; m_ack[i] = 0;
    end
    last_winner = 1;
    running = 0; elapsed = 0;
    m_freq = 0; m_cur = 0; m_prev = 0; m_has_cur = 0;
    m_new_f = 0; m_swap = 0; m_tmo = 0;
  endtask

  task automatic model_step();
    int winner;
    int reqs[2];
    int vals[2];
    reqs[0] = int'(req_a); reqs[1] = int'(req_b);
    vals[0] = int'(freq_a); vals[1] = int'(freq_b);
    m_new_f = 0; m_swap = 0; m_tmo = 0;
    m_ack[0] = reqs[0]; m_ack[1] = reqs[1];
    if (!running) begin
      if (slot_pending[0] || slot_pending[1]) begin
        if (slot_pending[0] && slot_pending[1]) winner = 1 - last_winner;
        else winner = slot_pending[0] ? 0 : 1;
        slot_pending[winner] = 0;
        if (!(m_has_cur && slot_value[winner] == m_cur)) begin
          m_new_f = 1; m_freq = slot_value[winner];
          last_winner = winner; running = 1; elapsed = 0;
        end
      end
    end else begin
      if (wave_ready) begin
        m_prev = m_cur; m_cur = m_freq; m_has_cur = 1; m_swap = 1; running = 0;
      end else if (elapsed == TMO - 1) begin
        m_tmo = 1; running = 0;
      end else begin
        elapsed++;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (reqs[i]) begin
        slot_pending[i] = 1; slot_value[i] = clamp(vals[i]);
      end
    end
  endtask

  task automatic compare_all();
    check("ack_a", int'(ack_a), m_ack[0]);
    check("ack_b", int'(ack_b), m_ack[1]);
    check("new_f", int'(new_f), m_new_f);
    check("frequency", int'(frequency), m_freq);
    check("busy", int'(busy), running);
    check("cur_freq", int'(cur_freq), m_cur);
    check("prev_freq", int'(prev_freq), m_prev);
    check("swap", int'(swap), m_swap);
    check("timeout_err", int'(timeout_err), m_tmo);
  endtask

  task automatic cycle();
    @(posedge clock);
    if (!reset_n) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  task automatic request(input int a_en, input int fa, input int b_en, input int fb);
    req_a = a_en[0]; freq_a = FW'(fa);
    req_b = b_en[0]; freq_b = FW'(fb);
    cycle();
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic wait_new_f(input string tag, input int exp_freq, input int budget);
    int found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      cycle();
      if (new_f) found = 1;
    end
    check({tag, "_issued"}, found, 1);
    check({tag, "_freq"}, int'(frequency), exp_freq);
  endtask

  task automatic pulse_ready(input string tag, input int exp_cur, input int exp_prev);
    wave_ready = 1'b1;
    cycle();
    wave_ready = 1'b0;
    check({tag, "_swap"}, int'(swap), 1);
    check({tag, "_cur"}, int'(cur_freq), exp_cur);
    check({tag, "_prev"}, int'(prev_freq), exp_prev);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) cycle();
    reset_n = 1'b1;
    cycle();
  endtask

  initial begin
    int n;
    int found;
    model_reset();
    reset_n = 1'b0;
    repeat (2) cycle();
    check("rst_busy", int'(busy), 0);
    check("rst_new_f", int'(new_f), 0);
    check("rst_cur", int'(cur_freq), 0);
    check("rst_freq", int'(frequency), 0);
    reset_n = 1'b1;
    cycle();

    // Single request with a long generator latency.
    request(1, 440, 0, 0);
    check("s1_ack_a", int'(ack_a), 1);
    cycle();
    check("s1_new_f", int'(new_f), 1);
    check("s1_freq", int'(frequency), 440);
    repeat (1022) cycle();
    pulse_ready("s1", 440, 0);
    cycle();
    check("s1_idle", int'(busy), 0);

    // Clamping at both ends.
    request(0, 0, 1, 100);
    wait_new_f("s2_low", 220, 8);
    repeat (5) cycle();
    pulse_ready("s2_low", 220, 440);
    request(0, 0, 1, 2000);
    wait_new_f("s2_high", 1760, 8);
    pulse_ready("s2_high", 1760, 220);

    // Tie after reset: A first, B right after A's swap; then B wins a tie after an A-only grant.
    do_reset();
    request(1, 330, 1, 550);
    wait_new_f("s3_first", 330, 4);
    repeat (3) cycle();
    pulse_ready("s3_first", 330, 0);
    cycle();
    check("s3_second_new_f", int'(new_f), 1);
    check("s3_second_freq", int'(frequency), 550);
    pulse_ready("s3_second", 550, 330);
    request(1, 600, 0, 0);
    wait_new_f("s3_a_only", 600, 4);
    request(1, 650, 1, 700);
    pulse_ready("s3_a_only", 600, 550);
    cycle();
    check("s3_rr_freq", int'(frequency), 700);
    pulse_ready("s3_rr_b", 700, 600);
    wait_new_f("s3_rr_a", 650, 4);
    pulse_ready("s3_rr_a", 650, 700);

    // Overwrite during WAIT: latest request wins.
    request(1, 440, 0, 0);
    wait_new_f("s4_run", 440, 4);
    request(1, 500, 0, 0);
    check("s4_ack1", int'(ack_a), 1);
    request(1, 600, 0, 0);
    check("s4_ack2", int'(ack_a), 1);
    pulse_ready("s4_run", 440, 650);
    wait_new_f("s4_next", 600, 4);
    pulse_ready("s4_next", 600, 440);
    found = 0;
    repeat (5) begin
      cycle();
      if (new_f) found = 1;
    end
    check("s4_no_extra", found, 0);

    // Duplicate of the current frequency is dropped.
    request(1, 600, 0, 0);
    check("s5_ack", int'(ack_a), 1);
    found = 0;
    repeat (4) begin
      cycle();
      if (new_f || busy) found = 1;
    end
    check("s5_dropped", found, 0);

    // Timeout after exactly TMO cycles in WAIT.
    request(0, 0, 1, 900);
    wait_new_f("s6_run", 900, 4);
    n = 0;
    found = 0;
    for (int i = 0; i < TMO + 10 && !found; i++) begin
      cycle();
      n++;
      if (timeout_err) found = 1;
    end
    check("s6_timeout_seen", found, 1);
    check("s6_timeout_cycles", n, TMO);
    check("s6_cur_kept", int'(cur_freq), 600);
    cycle();
    check("s6_idle", int'(busy), 0);

    // Asynchronous reset in the middle of WAIT, then a stale wave_ready.
    request(1, 1000, 0, 0);
    wait_new_f("s6_rst_run", 1000, 4);
    repeat (10) cycle();
    reset_n = 1'b0;
    #1;
    check("s6_rst_busy", int'(busy), 0);
    check("s6_rst_cur", int'(cur_freq), 0);
    check("s6_rst_prev", int'(prev_freq), 0);
    check("s6_rst_freq", int'(frequency), 0);
    check("s6_rst_ack", int'(ack_a), 0);
    model_reset();
    cycle();
    reset_n = 1'b1;
    cycle();
    wave_ready = 1'b1;
    cycle();
    wave_ready = 1'b0;
    check("s6_late_swap", int'(swap), 0);
    check("s6_late_cur", int'(cur_freq), 0);

    // Random traffic, ready pulses at random (including while idle).
    for (int i = 0; i < 4000; i++) begin
      int pick;
      req_a = ($urandom_range(0, 5) == 0);
      req_b = ($urandom_range(0, 5) == 0);
      pick = $urandom_range(0, 3);
      freq_a = (pick == 0) ? FW'(440) : (pick == 1) ? FW'(m_cur) : FW'($urandom_range(0, 2047));
      freq_b = ($urandom_range(0, 1) == 0) ? FW'(880) : FW'($urandom_range(0, 2047));
      wave_ready = ($urandom_range(0, 15) == 0);
      cycle();
    end
    req_a = 1'b0; req_b = 1'b0; wave_ready = 1'b0;
    repeat (3) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
